fifo_stream_reader: RTL and testbench

//  Read-side adapter for the 36-bit sync FIFO.
//  - Drains the FIFO's registered read port (1-cycle read latency) and presents a

---
 rtl/fifo_stream_reader.sv | 76 +++++++
 tb/tb_fifo_stream_reader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Read-side adapter for the 36-bit sync FIFO: prefetches through a 2-entry buffer
// and presents a valid/ready stream of 32-bit data plus a 4-bit lane control field.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 36,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic [31:0]           out_data,
    output logic [3:0]            out_ctrl,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNT_WIDTH-1:0]  word_cnt
);

    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
    logic [1:0]            count_q, count_d;
    logic                  inflight_q;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic                  pop;
    logic [2:0]            occ;
    logic [1:0]            tail;

    always_comb begin
        pop    = (count_q != 2'd0) && out_ready;
        // Occupancy counts words held plus the one still arriving from the FIFO.
        occ    = {1'b0, count_q} + {2'b00, inflight_q};
        tail   = count_q - {1'b0, pop};
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        cnt_d  = cnt_q + {{(CNT_WIDTH-1){1'b0}}, pop};

        fifo_rd_en = !rst && !fifo_empty && (occ < (3'd2 + {2'b00, pop}));

        if (pop) begin
            buf0_d = buf1_q;
        end
        // The arriving word lands behind whatever survives this cycle's pop.
        if (inflight_q) begin
            if (tail == 2'd0) begin
                buf0_d = fifo_rd_data;
            end else begin
                buf1_d = fifo_rd_data;
            end
        end

        count_d = 2'(occ - {2'b00, pop});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf0_q     <= '0;
            buf1_q     <= '0;
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            count_q    <= count_d;
            inflight_q <= fifo_rd_en;
            cnt_q      <= cnt_d;
        end
    end

    assign out_valid = (count_q != 2'd0);
    assign out_data  = buf0_q[35:4];
    assign out_ctrl  = buf0_q[3:0];
    assign word_cnt  = cnt_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a queue-based FIFO model feeds the reader, a
// scoreboard holds expected words, and a forked monitor checks every transfer.
module tb_fifo_stream_reader;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        out_ready;
    logic        fifo_empty;
    logic [35:0] fifo_rd_data = '0;
    logic        fifo_rd_en;
    logic [31:0] out_data;
    logic [3:0]  out_ctrl;
    logic        out_valid;
    logic [31:0] word_cnt;

    logic        fifo_rd_en4;
    logic [31:0] out_data4;
    logic [3:0]  out_ctrl4;
    logic        out_valid4;
    logic [3:0]  word_cnt4;

    int          wr_total = 0;
    int          rd_total = 0;
    logic [35:0] fq[$];
    logic [35:0] exp_q[$];

    int          checks = 0;
    int          errors = 0;
    int          mcnt   = 0;
    logic        stall  = 1'b0;
    logic [35:0] held   = '0;
    logic [35:0] expw;

    assign fifo_empty = (wr_total == rd_total);

    fifo_stream_reader #(.DATA_WIDTH(36), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
        .fifo_rd_en(fifo_rd_en), .out_data(out_data), .out_ctrl(out_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .word_cnt(word_cnt)
    );

    // Narrow-counter build sees the same stream, to exercise counter wrap.
    fifo_stream_reader #(.DATA_WIDTH(36), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
        .fifo_rd_en(fifo_rd_en4), .out_data(out_data4), .out_ctrl(out_ctrl4),
        .out_valid(out_valid4), .out_ready(out_ready), .word_cnt(word_cnt4)
    );

    // Sync FIFO model with one cycle of read latency.
    always @(posedge clk) begin
        if (rst) begin
            rd_total <= 0;
        end else if (fifo_rd_en) begin
            if (fq.size() > 0) fifo_rd_data <= fq.pop_front();
            rd_total <= rd_total + 1;
        end
    end

    task chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task push(input logic [35:0] w);
        fq.push_back(w);
        exp_q.push_back(w);
        wr_total++;
    endtask

    task tick();
        @(posedge clk);
        #1;
    endtask

    task monitor_loop();
        forever begin
            @(negedge clk);
            if (rst) begin
                mcnt  = 0;
                stall = 1'b0;
            end else begin
                if (fifo_empty) chk("rd_en_while_empty", 64'(fifo_rd_en), 64'd0);
                if (stall) begin
                    chk("hold_valid", 64'(out_valid), 64'd1);
                    chk("hold_data", 64'({out_data, out_ctrl}), 64'(held));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_word", 64'({out_data, out_ctrl}), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        expw = exp_q.pop_front();
                        chk("out_data", 64'(out_data), 64'(expw[35:4]));
                        chk("out_ctrl", 64'(out_ctrl), 64'(expw[3:0]));
                    end
                    chk("word_cnt", 64'(word_cnt), 64'(mcnt));
                    chk("word_cnt4", 64'(word_cnt4), 64'(mcnt % 16));
                    mcnt++;
                end
                stall = out_valid && !out_ready;
                held  = {out_data, out_ctrl};
            end
        end
    endtask

    task drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            tick();
            n++;
        end
        chk(name, 64'(exp_q.size() != 0 || out_valid), 64'd0);
    endtask

    initial begin
        int pops;
        int nw;
        int cyc;
        rst       = 1'b1;
        out_ready = 1'b1;
        fork
            monitor_loop();
        join_none

        // Reset with data sitting in the FIFO.
        push(36'h1_1111_1111);
        push(36'h2_2222_2222);
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
            chk("rst_valid", 64'(out_valid), 64'd0);
            chk("rst_cnt", 64'(word_cnt), 64'd0);
            chk("rst_data", 64'({out_data, out_ctrl}), 64'd0);
        end
        tick();
        fq.delete();
        exp_q.delete();
        wr_total = 0;
        rst      = 1'b0;
        tick();

        // Latency: single word into an empty FIFO.
        push(36'h1234_5678_A);
        @(negedge clk);
        chk("lat_rd_en_c0", 64'(fifo_rd_en), 64'd1);
        @(negedge clk);
        chk("lat_valid_c1", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("lat_valid_c2", 64'(out_valid), 64'd1);
        chk("lat_data", 64'(out_data), 64'h1234_5678);
        chk("lat_ctrl", 64'(out_ctrl), 64'hA);
        @(negedge clk);
        chk("lat_cnt", 64'(word_cnt), 64'd1);
        chk("lat_valid_c3", 64'(out_valid), 64'd0);
        tick();

        // Streaming: 8 words, no bubbles.
        for (int i = 0; i < 8; i++) push({32'hA000_0000 + 32'(i), 4'(i)});
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            if (c >= 2 && c <= 9) chk("stream_valid", 64'(out_valid), 64'd1);
            if (c == 10) chk("stream_end", 64'(out_valid), 64'd0);
        end
        chk("stream_cnt", 64'(word_cnt), 64'd9);
        tick();

        // Backpressure: 6 words queued, ready low for 10 cycles.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push({32'hB000_0000 + 32'(i), 4'(i + 1)});
        pops = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (fifo_rd_en) pops++;
        end
        chk("bp_pops", 64'(pops), 64'd2);
        chk("bp_valid", 64'(out_valid), 64'd1);
        chk("bp_data", 64'({out_data, out_ctrl}), 64'hB_0000_0001);
        tick();
        out_ready = 1'b1;
        drain("bp_drain");
        chk("bp_cnt", 64'(word_cnt), 64'd15);
        chk("wrap_pre", 64'(word_cnt4), 64'd15);

        // Wrap of the 4-bit counter.
        push(36'hC_AFE0_0005);
        drain("wrap_drain");
        chk("wrap_cnt4", 64'(word_cnt4), 64'd0);
        chk("wrap_cnt32", 64'(word_cnt), 64'd16);

        // Random writes and random backpressure.
        nw = 0;
        for (cyc = 0; cyc < 30000; cyc++) begin
            tick();
            if (nw < 1000 && $urandom_range(0, 1) == 1) begin
                push({$urandom, 4'($urandom_range(0, 15))});
                nw++;
            end
            out_ready = ($urandom_range(0, 1) == 1);
            if (nw == 1000 && exp_q.size() == 0) break;
        end
        chk("rand_written", 64'(nw), 64'd1000);
        out_ready = 1'b1;
        drain("rand_drain");
        tick();
        chk("rand_cnt", 64'(word_cnt), 64'd1016);
        chk("rand_cnt4", 64'(word_cnt4), 64'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
